// File: rtl/line_buf_pkg.sv
// Shared constants and FSM state type for the port-B line buffer read streamer.
package line_buf_pkg;

    localparam int LB_AW    = 10;
    localparam int LB_DW    = 16;
    localparam int LB_DEPTH = 1024;

    typedef enum logic [1:0] {
        LB_IDLE  = 2'd0,
        LB_RUN   = 2'd1,
        LB_DRAIN = 2'd2,
        LB_DONE  = 2'd3
    } lb_stream_state_t;

endpackage

// File: rtl/lb_skid_fifo.sv
// Two-entry fall-through FIFO holding {last, data} pairs; a word arriving while
// the FIFO is empty is presented on the output in the same cycle.
module lb_skid_fifo #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [1:0]    count
);

    logic [DW:0] mem_q [2];
    logic [DW:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        empty;
    logic        accept;
    logic        take;
    logic        store;

    always_comb begin
        empty     = (count_q == 2'd0);
        out_valid = !empty || push;
        out_data  = '0;
        out_last  = 1'b0;
        if (!empty) begin
            out_data = mem_q[rd_ptr_q][DW-1:0];
            out_last = mem_q[rd_ptr_q][DW];
        end else if (push) begin
            out_data = push_data;
            out_last = push_last;
        end

        // A word consumed straight from the input while empty is never stored.
        accept = out_valid && out_ready;
        take   = accept && !empty;
        store  = push && !(accept && empty);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (store) begin
                mem_d[wr_ptr_q] = {push_last, push_data};
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (take) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, store} - {1'b0, take};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dpb_line_streamer.sv
// Port-B read streamer: one BRAM read per cycle, returns buffered in a 2-entry FIFO, valid/ready output.
// Define LINE_STREAMER_REPEAT_EN to add repeat_mode (continuous re-streaming of the same window).
module dpb_line_streamer
    import line_buf_pkg::*;
#(
    parameter int AW = LB_AW,
    parameter int DW = LB_DW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
`ifdef LINE_STREAMER_REPEAT_EN
    input  logic          repeat_mode,
`endif
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          mem_ceb,
    output logic          mem_oceb,
    output logic [AW-1:0] mem_adb,
    input  logic [DW-1:0] mem_doutb,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    lb_stream_state_t state_q, state_d;
    logic [AW:0]      len_q, len_d;
    logic [AW:0]      issued_q, issued_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;
    logic             flush;
    logic             credit_ok;
    logic             issue;
    logic             last_issue;
    logic             rpt_active;
    logic [1:0]       fifo_count;
`ifdef LINE_STREAMER_REPEAT_EN
    logic [AW-1:0]    base_q, base_d;
    logic             rpt_q, rpt_d;
`endif

    // Credit: stored words plus the one in flight may never exceed the two FIFO slots.
    always_comb begin
        flush      = abort && ((state_q == LB_RUN) || (state_q == LB_DRAIN));
        credit_ok  = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && !inflight_q);
        issue      = (state_q == LB_RUN) && !abort && (issued_q < len_q) && credit_ok;
        last_issue = ((issued_q + (AW+1)'(1)) == len_q);
`ifdef LINE_STREAMER_REPEAT_EN
        rpt_active = rpt_q;
`else
        rpt_active = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= LB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LB_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? LB_DONE : LB_RUN;
                end
            end
            LB_RUN: begin
                if (abort) begin
                    state_d = LB_DONE;
                end else if (issue && last_issue && !rpt_active) begin
                    state_d = LB_DRAIN;
                end
            end
            LB_DRAIN: begin
                if (abort || (m_valid && m_ready && m_last)) begin
                    state_d = LB_DONE;
                end
            end
            LB_DONE: begin
                state_d = LB_IDLE;
            end
            default: begin
                state_d = LB_IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != LB_IDLE);
        done     = (state_q == LB_DONE);
        mem_ceb  = issue;
        mem_oceb = 1'b1;
        mem_adb  = addr_q;
    end

    always_comb begin
        len_d           = len_q;
        issued_d        = issued_q;
        addr_d          = addr_q;
        inflight_d      = issue;
        inflight_last_d = issue && last_issue;
`ifdef LINE_STREAMER_REPEAT_EN
        base_d          = base_q;
        rpt_d           = rpt_q;
`endif
        if ((state_q == LB_IDLE) && start) begin
            len_d    = length;
            addr_d   = base_addr;
            issued_d = '0;
`ifdef LINE_STREAMER_REPEAT_EN
            base_d   = base_addr;
            rpt_d    = repeat_mode;
`endif
        end else if (issue) begin
            addr_d   = (32'(addr_q) == LB_DEPTH - 1) ? '0 : addr_q + AW'(1);
            issued_d = issued_q + (AW+1)'(1);
`ifdef LINE_STREAMER_REPEAT_EN
            if (rpt_q && last_issue) begin
                addr_d   = base_q;
                issued_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            len_q           <= '0;
            issued_q        <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
`ifdef LINE_STREAMER_REPEAT_EN
            base_q          <= '0;
            rpt_q           <= 1'b0;
`endif
        end else begin
            len_q           <= len_d;
            issued_q        <= issued_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
`ifdef LINE_STREAMER_REPEAT_EN
            base_q          <= base_d;
            rpt_q           <= rpt_d;
`endif
        end
    end

    lb_skid_fifo #(
        .DW(DW)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (inflight_q),
        .push_data (mem_doutb),
        .push_last (inflight_last_q),
        .out_ready (m_ready),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_last  (m_last),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_dpb_line_streamer.sv
// Randomized bench for dpb_line_streamer: BRAM model plus a stream reference derived from base/length.
module tb_dpb_line_streamer;
    import line_buf_pkg::*;

    localparam int AW = LB_AW;
    localparam int DW = LB_DW;

    logic          clk       = 1'b0;
    logic          resetn    = 1'b0;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length    = '0;
    logic          abort     = 1'b0;
    logic          m_ready   = 1'b0;
    logic [DW-1:0] mem_doutb = '0;
    logic          busy, done, mem_ceb, mem_oceb, m_valid, m_last;
    logic [AW-1:0] mem_adb;
    logic [DW-1:0] m_data;
`ifdef LINE_STREAMER_REPEAT_EN
    logic          rpt_in = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] bram [LB_DEPTH];

    // Observations of the most recent transfer
    logic [DW-1:0] got_data[$];
    bit            got_last[$];
    int            got_cyc[$];
    int            got_addr[$];
    int            done_cyc, done_cnt, max_out, stall_err, valid_cnt, valid_after_abort;
    bit            busy_at_start;
    logic [6:0]    rst_snap;

    dpb_line_streamer dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
`ifdef LINE_STREAMER_REPEAT_EN
        .repeat_mode (rpt_in),
`endif
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mem_ceb   (mem_ceb),
        .mem_oceb  (mem_oceb),
        .mem_adb   (mem_adb),
        .mem_doutb (mem_doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ceb) mem_doutb <= bram[mem_adb];
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic logic ready_at(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((k % 3) == 1);
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [DW-1:0] exp_word(input int b, input int i);
        return bram[(b + i) % LB_DEPTH];
    endfunction

    // Drives one start command (cycle 0) and records what the DUT does, cycle by cycle.
    task automatic do_transfer(input int b, input int len, input int rmode, input int abort_cyc,
                               input int spur_cyc, input int rst_cyc, input int limit);
        int issued_n = 0;
        int accepted_n = 0;
        bit prev_stall = 1'b0;
        bit disturbed = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        got_data.delete(); got_last.delete(); got_cyc.delete(); got_addr.delete();
        done_cyc = -1; done_cnt = 0; max_out = 0; stall_err = 0; valid_cnt = 0;
        valid_after_abort = -1; rst_snap = '1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(b); length = (AW+1)'(len); abort = 1'b0;
        m_ready = ready_at(rmode, 0);
        #1;
        busy_at_start = busy;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            start = (k == spur_cyc);
            if (k == spur_cyc) begin
                base_addr = ~AW'(b);
                length = (AW+1)'(5);
            end
            abort = (k == abort_cyc);
            if (k == rst_cyc) resetn = 1'b0;
            if (k == rst_cyc + 1) resetn = 1'b1;
            m_ready = ready_at(rmode, k);
            #1;
            if (k == rst_cyc + 1) rst_snap = {busy, done, mem_ceb, m_valid, m_last, |mem_adb, |m_data};
            if (k == abort_cyc + 1) valid_after_abort = int'(m_valid);
            if (prev_stall && !disturbed &&
                (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last)) stall_err++;
            if (mem_ceb === 1'b1) begin
                got_addr.push_back(int'(mem_adb));
                issued_n++;
            end
            if (issued_n - accepted_n > max_out) max_out = issued_n - accepted_n;
            if (m_valid === 1'b1) valid_cnt++;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_cyc.push_back(k);
                accepted_n++;
            end
            prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
            prev_data = m_data;
            prev_last = m_last;
            if (k == abort_cyc || k == rst_cyc) disturbed = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done === 1'b1 && rst_cyc < 0) break;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (mem_ceb !== 1'b0) begin errors++; $display("FAIL reset_ceb got=%0b exp=0", mem_ceb); end
        checks++; if (mem_adb !== '0) begin errors++; $display("FAIL reset_adb got=%h exp=0", mem_adb); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%0b exp=0", m_last); end
        checks++; if (mem_oceb !== 1'b1) begin errors++; $display("FAIL reset_oceb got=%0b exp=1", mem_oceb); end
        resetn = 1'b1;
        @(posedge clk); #2;
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy=%0b valid=%0b exp=0/0", busy, m_valid);
        end
    endtask

    task automatic test_basic();
        do_transfer(32'h010, 4, 0, -1, -1, -1, 40);
        $display("basic: words=%0d done_cyc=%0d", got_data.size(), done_cyc);
        checks++; if (got_data.size() != 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++;
            if (got_data[i] !== exp_word(16, i) || got_last[i] !== (i == 3) || got_cyc[i] != 2 + i) begin
                errors++;
                $display("FAIL basic_word%0d got=%h/%0b@%0d exp=%h/%0b@%0d", i, got_data[i], got_last[i],
                         got_cyc[i], exp_word(16, i), (i == 3), 2 + i);
            end
        end
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=6", done_cyc); end
    endtask

    task automatic test_wrap();
        do_transfer(32'h3FE, 4, 0, -1, -1, -1, 40);
        $display("wrap: reads=%0d", got_addr.size());
        checks++; if (got_addr.size() != 4) begin errors++; $display("FAIL wrap_reads got=%0d exp=4", got_addr.size()); end
        for (int i = 0; i < got_addr.size() && i < 4; i++) begin
            checks++;
            if (got_addr[i] != (32'h3FE + i) % LB_DEPTH) begin
                errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, got_addr[i], (32'h3FE + i) % LB_DEPTH);
            end
        end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++;
            if (got_data[i] !== exp_word(32'h3FE, i)) begin
                errors++; $display("FAIL wrap_data%0d got=%h exp=%h", i, got_data[i], exp_word(32'h3FE, i));
            end
        end
    endtask

    task automatic test_backpressure();
        int b = int'($urandom_range(0, LB_DEPTH - 1));
        do_transfer(b, 8, 1, -1, -1, -1, 100);
        $display("backpressure: base=%h words=%0d max_out=%0d", b, got_data.size(), max_out);
        checks++; if (got_data.size() != 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            checks++;
            if (got_data[i] !== exp_word(b, i) || got_last[i] !== (i == 7)) begin
                errors++; $display("FAIL bp_word%0d got=%h/%0b exp=%h/%0b", i, got_data[i], got_last[i],
                                   exp_word(b, i), (i == 7));
            end
        end
        checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding got=%0d exp<=2", max_out); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_zero_length();
        do_transfer(32'h155, 0, 0, -1, 1, -1, 20);
        $display("zero_length: reads=%0d valid=%0d done_cyc=%0d", got_addr.size(), valid_cnt, done_cyc);
        checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL zero_reads got=%0d exp=0", got_addr.size()); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL zero_valid got=%0d exp=0", valid_cnt); end
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc); end
    endtask

    task automatic test_back_to_back();
        do_transfer(32'h3FF, 1, 0, -1, -1, -1, 20);
        $display("back_to_back: words=%0d done_cyc=%0d", got_data.size(), done_cyc);
        checks++; if (busy_at_start !== 1'b0) begin errors++; $display("FAIL b2b_busy_start got=%0b exp=0", busy_at_start); end
        checks++;
        if (got_data.size() != 1 || got_data[0] !== exp_word(32'h3FF, 0) || got_last[0] !== 1'b1) begin
            errors++; $display("FAIL b2b_single_word count=%0d exp=1 word/last", got_data.size());
        end
        checks++; if (done_cyc != 3) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=3", done_cyc); end
    endtask

    task automatic test_abort();
        int lasts = 0;
        do_transfer(32'h040, 16, 0, 3, -1, -1, 60);
        foreach (got_last[i]) if (got_last[i]) lasts++;
        $display("abort: words=%0d done_cyc=%0d", got_data.size(), done_cyc);
        checks++; if (done_cyc != 4) begin errors++; $display("FAIL abort_done_cycle got=%0d exp=4", done_cyc); end
        checks++; if (valid_after_abort != 0) begin errors++; $display("FAIL abort_valid_drop got=%0d exp=0", valid_after_abort); end
        checks++; if (lasts != 0) begin errors++; $display("FAIL abort_no_last got=%0d exp=0", lasts); end
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL abort_count got=%0d exp=2", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_word(32'h040, i)) begin
                errors++; $display("FAIL abort_word%0d got=%h exp=%h", i, got_data[i], exp_word(32'h040, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_transfer(32'h080, 16, 0, -1, -1, 5, 12);
        $display("reset_mid: snap=%b done_cnt=%0d", rst_snap, done_cnt);
        checks++; if (rst_snap !== 7'b0) begin errors++; $display("FAIL rstmid_outputs got=%b exp=0000000", rst_snap); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int b = int'($urandom_range(0, LB_DEPTH - 1));
            int len = int'($urandom_range(1, 40));
            int bad = 0;
            do_transfer(b, len, 2, -1, 3, -1, 40 * len + 50);
            for (int i = 0; i < got_data.size() && i < len; i++) begin
                if (got_data[i] !== exp_word(b, i) || got_last[i] !== (i == len - 1)) bad++;
            end
            $display("random %0d: base=%h len=%0d words=%0d bad=%0d max_out=%0d", t, b, len,
                     got_data.size(), bad, max_out);
            checks++; if (got_data.size() != len) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d", got_data.size(), len); end
            checks++; if (bad != 0) begin errors++; $display("FAIL rnd_words bad=%0d exp=0", bad); end
            checks++; if (max_out > 2) begin errors++; $display("FAIL rnd_outstanding got=%0d exp<=2", max_out); end
            checks++; if (stall_err != 0) begin errors++; $display("FAIL rnd_stall_stable got=%0d exp=0", stall_err); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd_done_count got=%0d exp=1", done_cnt); end
        end
    endtask

    task automatic test_max_length();
        int bad = 0;
        do_transfer(32'h2F0, 1024, 0, -1, -1, -1, 1100);
        for (int i = 0; i < got_data.size() && i < 1024; i++) begin
            if (got_data[i] !== exp_word(32'h2F0, i) || got_last[i] !== (i == 1023)) bad++;
        end
        $display("max_length: words=%0d bad=%0d done_cyc=%0d", got_data.size(), bad, done_cyc);
        checks++; if (got_data.size() != 1024) begin errors++; $display("FAIL max_count got=%0d exp=1024", got_data.size()); end
        checks++; if (bad != 0) begin errors++; $display("FAIL max_words bad=%0d exp=0", bad); end
        checks++; if (done_cyc != 1026) begin errors++; $display("FAIL max_done_cycle got=%0d exp=1026", done_cyc); end
    endtask

`ifdef LINE_STREAMER_REPEAT_EN
    task automatic test_repeat();
        int b = int'($urandom_range(0, LB_DEPTH - 1));
        int bad = 0;
        rpt_in = 1'b1;
        do_transfer(b, 3, 0, 14, -1, -1, 60);
        rpt_in = 1'b0;
        for (int i = 0; i < got_data.size(); i++) begin
            if (got_data[i] !== exp_word(b, i % 3) || got_last[i] !== ((i % 3) == 2)) bad++;
        end
        $display("repeat: base=%h words=%0d bad=%0d done_cyc=%0d", b, got_data.size(), bad, done_cyc);
        checks++; if (got_data.size() != 13) begin errors++; $display("FAIL rpt_count got=%0d exp=13", got_data.size()); end
        checks++; if (bad != 0) begin errors++; $display("FAIL rpt_words bad=%0d exp=0", bad); end
        checks++; if (done_cyc != 15) begin errors++; $display("FAIL rpt_done_cycle got=%0d exp=15", done_cyc); end
    endtask
`endif

    initial begin
        for (int i = 0; i < LB_DEPTH; i++) bram[i] = DW'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        test_max_length();
`ifdef LINE_STREAMER_REPEAT_EN
        test_repeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
